oled_spi_arbiter: RTL and testbench
===================================

# oled_spi_arbiter

Two-port arbiter for the single OLED SPI write engine. Port 0 is the OLED init sequencer and port 1 is the pixel/command drawing engine. It grants the writer to one requester at a time, holds the grant across multi-byte command bursts, and recovers from a writer that never reports completion. It sits between the requesters and the SPI writer, and each side keeps its existing level-START / pulse-DONE handshake.

## Interface
- `DW`, default 10: word width. Bits [9:8] are the D/C and control bits; bits [7:0] are the byte.
- `TIMEOUT`, default 20'd100000: number of cycles in XFER without `SPI_DONE` before the transfer is aborted.
- `GAP_MAX`, default 8'd255: maximum number of cycles a locked owner may idle in GAP before the grant is released.
- `CLK`  in  1: the single clock. All logic is on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `REQ0_START`  in  1: port 0 write request. Level signal, held until `REQ0_DONE`.
- `REQ0_LOCK`  in  1: port 0 asks to keep the grant after the current word completes.
- `REQ0_DATA`  in  DW: port 0 word. Must be stable while `REQ0_START` is high.
- `REQ0_DONE`  out  1: one-cycle completion pulse to port 0.
- `REQ1_START`, `REQ1_LOCK`, `REQ1_DATA`, `REQ1_DONE`: the same set for port 1.
- `SPI_START`  out  1: write request to the SPI writer.
- `SPI_DATA`  out  DW: word presented to the SPI writer.
- `SPI_DONE`  in  1: one-cycle completion pulse from the SPI writer.
- `GRANT`  out  2: one-hot current owner (bit0 = port 0). Zero in IDLE.
- `BUSY`  out  1: high in any state other than IDLE.
- `TIMEOUT_ERR`  out  1: sticky error flag.
- `ERR_CLR`  in  1: clears `TIMEOUT_ERR`.

## Operation
- States are IDLE, XFER and GAP. The block keeps a registered owner bit.
- **IDLE**
  - If `REQ0_START` is high: owner ← 0, latch `REQ0_DATA` into `SPI_DATA`, go to XFER.
  - Otherwise, if `REQ1_START` is high: owner ← 1, latch `REQ1_DATA`, go to XFER.
  - Port 0 has fixed priority when both requesters are active.
- **XFER**
  - `SPI_START` = 1 and `SPI_DATA` holds the latched word.
  - The timeout counter increments every cycle.
  - On `SPI_DONE`:
    - The owner's `REQn_DONE` is driven combinationally as `SPI_DONE & XFER & owner==n`.
    - `SPI_START` goes to 0 at the next edge and the counter clears.
    - If the owner's LOCK is high in that cycle, go to GAP; otherwise go to IDLE.
- **GAP**
  - The grant is held and `SPI_START` = 0.
  - A gap counter increments every cycle.
  - Owner START high: latch the owner's DATA, go to XFER. The other port is ignored.
  - Owner LOCK low with owner START low: go to IDLE.
  - Gap counter reaches `GAP_MAX`: go to IDLE. `TIMEOUT_ERR` is not set.
- **One-cycle guard**
  - In the cycle directly after a DONE, the owner's START is ignored in both IDLE and GAP.
  - This tolerates requesters that drop START one edge late.
  - The guard does not block the other port in IDLE.
- **Timeout**
  - Trigger: the XFER counter reaches `TIMEOUT` with no `SPI_DONE`.
  - Response: pulse the owner's DONE for one cycle so the requester cannot deadlock, set `TIMEOUT_ERR`, drop `SPI_START`, go to IDLE. LOCK is discarded.
- `SPI_DONE` outside XFER is ignored and produces no `REQn_DONE`.
- If `ERR_CLR` and a timeout occur in the same cycle, set wins.
- The counter is 20 bits and saturates at compare; there is no wrap-around.

## Timing
- **Reset values:** `SPI_START` = 0, `SPI_DATA` = 10'h300, `GRANT` = 2'b00, `BUSY` = 0, `TIMEOUT_ERR` = 0, `REQn_DONE` = 0, state = IDLE, counters = 0.
- `RST` asserted mid-transfer clears all outputs immediately, without waiting for a clock edge.
- **Grant latency:** START is sampled high at edge k; `SPI_START`, `SPI_DATA` and `GRANT` are valid from edge k onward, i.e. one cycle of latency.
- **Completion:** `REQn_DONE` is asserted in the same cycle as `SPI_DONE`. The state changes at the end of that cycle.
- **Back-to-back locked burst:** DONE at cycle t, guard at t+1, START seen at t+2 at the earliest, `SPI_START` re-asserted at t+3.
- `SPI_DATA` holds its last latched value in IDLE and GAP.

## Test plan
1. Port 0 presents 10'h0AE and holds START; SPI_DONE is returned 8 cycles after SPI_START.
   - `SPI_START` rises 1 cycle after REQ0_START with `SPI_DATA` = 10'h0AE and `GRANT` = 01.
   - `REQ0_DONE` pulses in the same cycle as `SPI_DONE`.
   - The block returns to IDLE with `BUSY` = 0.
2. Both ports assert START in the same cycle.
   - Port 0 is served first.
   - Port 1 is granted 1 cycle after port 0 returns to IDLE, with `GRANT` = 10.
3. Port 0 sends 10'h081 then 10'h0FF with LOCK high, while port 1 requests throughout.
   - Both port-0 words complete before `GRANT` changes.
   - The second `SPI_START` follows the first DONE by at least 3 cycles.
4. SPI_DONE is withheld, with `TIMEOUT` = 20.
   - At XFER cycle 20: `REQn_DONE` pulses, `TIMEOUT_ERR` = 1, `SPI_START` = 0, state = IDLE.
   - `ERR_CLR` then clears `TIMEOUT_ERR`; an `ERR_CLR` in the same cycle as a timeout leaves it at 1.
5. Owner holds LOCK with no START, with `GAP_MAX` = 10.
   - The grant is released after 10 GAP cycles.
   - `TIMEOUT_ERR` stays 0.
6. Assert `RST` mid-XFER, then release it.
   - All outputs go to their reset values immediately.
   - A stray `SPI_DONE` in IDLE produces no `REQn_DONE`.

Source files
------------

// File: rtl/oled_spi_arbiter.sv
// Two-port arbiter in front of the OLED SPI write engine.
// Port 0 (init sequencer) has priority; lock holds the grant across bursts.
module oled_spi_arbiter #(
   parameter int          DW      = 10,
   parameter logic [19:0] TIMEOUT = 20'd100000,
   parameter logic [7:0]  GAP_MAX = 8'd255
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0_START,
   input  logic          REQ0_LOCK,
   input  logic [DW-1:0] REQ0_DATA,
   output logic          REQ0_DONE,
   input  logic          REQ1_START,
   input  logic          REQ1_LOCK,
   input  logic [DW-1:0] REQ1_DATA,
   output logic          REQ1_DONE,
   output logic          SPI_START,
   output logic [DW-1:0] SPI_DATA,
   input  logic          SPI_DONE,
   output logic [1:0]    GRANT,
   output logic          BUSY,
   output logic          TIMEOUT_ERR,
   input  logic          ERR_CLR
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [DW-1:0] RST_DATA = DW'(10'h300);

   state_t        state, state_n;
   logic          owner, owner_n;
   logic          guard;
   logic          load;
   logic          done_ev;
   logic          to_hit;
   logic [19:0]   tcnt, tcnt_inc;
   logic [7:0]    gcnt, gcnt_inc;
   logic          own_start, own_lock;
   logic          r0, r1;

   assign tcnt_inc  = tcnt + 20'd1;
   assign gcnt_inc  = gcnt + 8'd1;
   assign own_start = owner ? REQ1_START : REQ0_START;
   assign own_lock  = owner ? REQ1_LOCK  : REQ0_LOCK;

   // guard masks only the port that just finished
   assign r0 = REQ0_START & ~(guard & ~owner);
   assign r1 = REQ1_START & ~(guard &  owner);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_n;
         owner <= owner_n;
      end
   end

   always_comb begin
      state_n = state;
      owner_n = owner;
      load    = 1'b0;
      done_ev = 1'b0;
      to_hit  = 1'b0;
      unique case (state)
         IDLE: begin
            if (r0) begin
               owner_n = 1'b0;
               load    = 1'b1;
               state_n = XFER;
            end else if (r1) begin
               owner_n = 1'b1;
               load    = 1'b1;
               state_n = XFER;
            end
         end
         XFER: begin
            if (SPI_DONE) begin
               done_ev = 1'b1;
               state_n = own_lock ? GAP : IDLE;
            end else if (tcnt_inc >= TIMEOUT) begin
               done_ev = 1'b1;
               to_hit  = 1'b1;
               state_n = IDLE;
            end
         end
         GAP: begin
            if (own_start & ~guard) begin
               load    = 1'b1;
               state_n = XFER;
            end else if (~own_lock) begin
               state_n = IDLE;
            end else if (gcnt_inc >= GAP_MAX) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         SPI_DATA    <= RST_DATA;
         tcnt        <= '0;
         gcnt        <= '0;
         guard       <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         if (load)
            SPI_DATA <= owner_n ? REQ1_DATA : REQ0_DATA;
         tcnt  <= (state == XFER && state_n == XFER) ? tcnt_inc : '0;
         gcnt  <= (state == GAP && state_n == GAP) ? gcnt_inc : '0;
         guard <= done_ev;
         if (to_hit)
            TIMEOUT_ERR <= 1'b1;
         else if (ERR_CLR)
            TIMEOUT_ERR <= 1'b0;
      end
   end

   assign SPI_START = (state == XFER);
   assign BUSY      = (state != IDLE);
   assign GRANT     = BUSY ? {owner, ~owner} : 2'b00;
   assign REQ0_DONE = done_ev & ~owner;
   assign REQ1_DONE = done_ev &  owner;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Directed bench for oled_spi_arbiter.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_oled_spi_arbiter;

   localparam int DW = 10;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          REQ0_START = 1'b0;
   logic          REQ0_LOCK = 1'b0;
   logic [DW-1:0] REQ0_DATA = '0;
   logic          REQ0_DONE;
   logic          REQ1_START = 1'b0;
   logic          REQ1_LOCK = 1'b0;
   logic [DW-1:0] REQ1_DATA = '0;
   logic          REQ1_DONE;
   logic          SPI_START;
   logic [DW-1:0] SPI_DATA;
   logic          SPI_DONE = 1'b0;
   logic [1:0]    GRANT;
   logic          BUSY;
   logic          TIMEOUT_ERR;
   logic          ERR_CLR = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   oled_spi_arbiter #(
      .DW(DW),
      .TIMEOUT(20'd20),
      .GAP_MAX(8'd10)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .REQ0_START(REQ0_START),
      .REQ0_LOCK(REQ0_LOCK),
      .REQ0_DATA(REQ0_DATA),
      .REQ0_DONE(REQ0_DONE),
      .REQ1_START(REQ1_START),
      .REQ1_LOCK(REQ1_LOCK),
      .REQ1_DATA(REQ1_DATA),
      .REQ1_DONE(REQ1_DONE),
      .SPI_START(SPI_START),
      .SPI_DATA(SPI_DATA),
      .SPI_DONE(SPI_DONE),
      .GRANT(GRANT),
      .BUSY(BUSY),
      .TIMEOUT_ERR(TIMEOUT_ERR),
      .ERR_CLR(ERR_CLR)
   );

   task automatic test_reset();
      @(negedge CLK);
      n_chk++;
      if (SPI_START !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_spi_start got %b want 0", SPI_START);
      end
      n_chk++;
      if (SPI_DATA !== 10'h300) begin
         n_fail++;
         $display("FAIL rst_spi_data got %h want 300", SPI_DATA);
      end
      n_chk++;
      if (GRANT !== 2'b00 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_grant_busy got %b/%b want 00/0", GRANT, BUSY);
      end
      n_chk++;
      if (TIMEOUT_ERR !== 1'b0 || REQ0_DONE !== 1'b0 || REQ1_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_err_done got %b%b%b want 000",
                  TIMEOUT_ERR, REQ0_DONE, REQ1_DONE);
      end
      RST = 1'b0;
   endtask

   task automatic test_single();
      @(negedge CLK);
      REQ0_DATA  = 10'h0AE;
      REQ0_START = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (SPI_START !== 1'b1 || SPI_DATA !== 10'h0AE || GRANT !== 2'b01) begin
         n_fail++;
         $display("FAIL single_grant got %b %h %b want 1 0ae 01",
                  SPI_START, SPI_DATA, GRANT);
      end
      repeat (7) @(negedge CLK);
      SPI_DONE = 1'b1;
      #1;
      n_chk++;
      if (REQ0_DONE !== 1'b1 || REQ1_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done got %b%b want 10", REQ0_DONE, REQ1_DONE);
      end
      // requester keeps START up for two more edges
      @(negedge CLK);
      SPI_DONE = 1'b0;
      #1;
      n_chk++;
      if (BUSY !== 1'b0 || SPI_START !== 1'b0 || REQ0_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle got %b%b%b want 000",
                  BUSY, SPI_START, REQ0_DONE);
      end
      @(negedge CLK);
      n_chk++;
      if (BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL single_guard got busy %b want 0", BUSY);
      end
      REQ0_START = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (BUSY !== 1'b0 || SPI_DATA !== 10'h0AE) begin
         n_fail++;
         $display("FAIL single_hold got %b %h want 0 0ae", BUSY, SPI_DATA);
      end
   endtask

   task automatic test_priority();
      @(negedge CLK);
      REQ0_DATA  = 10'h0A5;
      REQ1_DATA  = 10'h1C3;
      REQ0_START = 1'b1;
      REQ1_START = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b01 || SPI_DATA !== 10'h0A5) begin
         n_fail++;
         $display("FAIL prio_first got %b %h want 01 0a5", GRANT, SPI_DATA);
      end
      repeat (2) @(negedge CLK);
      SPI_DONE = 1'b1;
      #1;
      n_chk++;
      if (REQ0_DONE !== 1'b1 || REQ1_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_done0 got %b%b want 10", REQ0_DONE, REQ1_DONE);
      end
      REQ0_START = 1'b0;
      @(negedge CLK);
      SPI_DONE = 1'b0;
      n_chk++;
      if (GRANT !== 2'b00 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_idle got %b %b want 00 0", GRANT, BUSY);
      end
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b10 || SPI_DATA !== 10'h1C3 || SPI_START !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_second got %b %h %b want 10 1c3 1",
                  GRANT, SPI_DATA, SPI_START);
      end
      @(negedge CLK);
      SPI_DONE = 1'b1;
      #1;
      n_chk++;
      if (REQ1_DONE !== 1'b1 || REQ0_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_done1 got %b%b want 10", REQ1_DONE, REQ0_DONE);
      end
      REQ1_START = 1'b0;
      @(negedge CLK);
      SPI_DONE = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge CLK);
      REQ0_DATA  = 10'h081;
      REQ0_LOCK  = 1'b1;
      REQ0_START = 1'b1;
      REQ1_DATA  = 10'h133;
      REQ1_START = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b01 || SPI_DATA !== 10'h081) begin
         n_fail++;
         $display("FAIL b2b_first got %b %h want 01 081", GRANT, SPI_DATA);
      end
      repeat (2) @(negedge CLK);
      SPI_DONE = 1'b1;
      #1;
      n_chk++;
      if (REQ0_DONE !== 1'b1 || REQ1_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done1 got %b%b want 10", REQ0_DONE, REQ1_DONE);
      end
      REQ0_DATA = 10'h0FF;
      @(negedge CLK);
      SPI_DONE = 1'b0;
      n_chk++;
      if (SPI_START !== 1'b0 || GRANT !== 2'b01 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap1 got %b %b %b want 0 01 1",
                  SPI_START, GRANT, BUSY);
      end
      @(negedge CLK);
      n_chk++;
      if (SPI_START !== 1'b0 || GRANT !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_gap2 got %b %b want 0 01", SPI_START, GRANT);
      end
      @(negedge CLK);
      n_chk++;
      if (SPI_START !== 1'b1 || SPI_DATA !== 10'h0FF || GRANT !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_second got %b %h %b want 1 0ff 01",
                  SPI_START, SPI_DATA, GRANT);
      end
      @(negedge CLK);
      REQ0_LOCK = 1'b0;
      SPI_DONE  = 1'b1;
      #1;
      n_chk++;
      if (REQ0_DONE !== 1'b1 || REQ1_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done2 got %b%b want 10", REQ0_DONE, REQ1_DONE);
      end
      REQ0_START = 1'b0;
      @(negedge CLK);
      SPI_DONE = 1'b0;
      n_chk++;
      if (GRANT !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_release got %b want 00", GRANT);
      end
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b10 || SPI_DATA !== 10'h133) begin
         n_fail++;
         $display("FAIL b2b_port1 got %b %h want 10 133", GRANT, SPI_DATA);
      end
      SPI_DONE = 1'b1;
      #1;
      REQ1_START = 1'b0;
      @(negedge CLK);
      SPI_DONE = 1'b0;
   endtask

   task automatic test_timeout();
      @(negedge CLK);
      REQ0_DATA  = 10'h0C0;
      REQ0_START = 1'b1;
      @(negedge CLK);
      repeat (18) @(negedge CLK);
      n_chk++;
      if (REQ0_DONE !== 1'b0 || SPI_START !== 1'b1) begin
         n_fail++;
         $display("FAIL to_cyc19 got %b %b want 0 1", REQ0_DONE, SPI_START);
      end
      @(negedge CLK);
      #1;
      n_chk++;
      if (REQ0_DONE !== 1'b1 || TIMEOUT_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL to_cyc20 got %b %b want 1 0", REQ0_DONE, TIMEOUT_ERR);
      end
      REQ0_START = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (TIMEOUT_ERR !== 1'b1 || SPI_START !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL to_after got %b %b %b want 1 0 0",
                  TIMEOUT_ERR, SPI_START, BUSY);
      end
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      n_chk++;
      if (TIMEOUT_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL to_clear got %b want 0", TIMEOUT_ERR);
      end
      REQ1_DATA  = 10'h1AA;
      REQ1_LOCK  = 1'b1;
      REQ1_START = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b10) begin
         n_fail++;
         $display("FAIL to_grant1 got %b want 10", GRANT);
      end
      repeat (19) @(negedge CLK);
      ERR_CLR = 1'b1;
      #1;
      n_chk++;
      if (REQ1_DONE !== 1'b1 || REQ0_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL to_done1 got %b%b want 10", REQ1_DONE, REQ0_DONE);
      end
      REQ1_START = 1'b0;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      n_chk++;
      if (TIMEOUT_ERR !== 1'b1 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL to_setwins got %b %b want 1 0", TIMEOUT_ERR, BUSY);
      end
      REQ1_LOCK = 1'b0;
      ERR_CLR   = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
   endtask

   task automatic test_gap_release();
      @(negedge CLK);
      REQ1_DATA  = 10'h1F0;
      REQ1_LOCK  = 1'b1;
      REQ1_START = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b10 || TIMEOUT_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_grant got %b %b want 10 0", GRANT, TIMEOUT_ERR);
      end
      @(negedge CLK);
      SPI_DONE = 1'b1;
      #1;
      REQ1_START = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         SPI_DONE = 1'b0;
         n_chk++;
         if (GRANT !== 2'b10 || SPI_START !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_hold%0d got %b %b want 10 0",
                     i, GRANT, SPI_START);
         end
      end
      @(negedge CLK);
      n_chk++;
      if (GRANT !== 2'b00 || BUSY !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_release got %b %b %b want 00 0 0",
                  GRANT, BUSY, TIMEOUT_ERR);
      end
      REQ1_LOCK = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      REQ0_DATA  = 10'h055;
      REQ0_START = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (SPI_START !== 1'b1 || SPI_DATA !== 10'h055) begin
         n_fail++;
         $display("FAIL ar_start got %b %h want 1 055", SPI_START, SPI_DATA);
      end
      @(negedge CLK);
      RST = 1'b1;
      #1;
      n_chk++;
      if (SPI_START !== 1'b0 || GRANT !== 2'b00 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_ctrl got %b %b %b want 0 00 0",
                  SPI_START, GRANT, BUSY);
      end
      n_chk++;
      if (SPI_DATA !== 10'h300) begin
         n_fail++;
         $display("FAIL ar_data got %h want 300", SPI_DATA);
      end
      @(negedge CLK);
      RST        = 1'b0;
      REQ0_START = 1'b0;
      @(negedge CLK);
      SPI_DONE = 1'b1;
      #1;
      n_chk++;
      if (REQ0_DONE !== 1'b0 || REQ1_DONE !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_stray got %b%b %b want 00 0",
                  REQ0_DONE, REQ1_DONE, BUSY);
      end
      @(negedge CLK);
      SPI_DONE = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_back_to_back();
      test_timeout();
      test_gap_release();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
